key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
Multi-channel input conditioner for the board push-buttons and switches: per channel it provides a configurable-depth synchronizer, a counter-based debouncer and one-cycle press/release edge pulses. Game FSMs consume `key_press` and `key_release` directly, so they need no edge detectors of their own. It sits between the top-level pins and all game logic, and replaces the bare two-flop synchronizer. All channels are independent and share one clock.

Parameters:
N, 4, number of input channels
SYNC_STAGES, 2, synchronizer flops per channel (legal range 2..4)
DEBOUNCE_CYCLES, 4, consecutive cycles a changed synced sample must persist before it is accepted (legal minimum 1)
ACTIVE_LOW, 1, 1 = raw input is pressed when 0 (DE1-SoC KEY); 0 = pressed when 1
REPEAT_DELAY, 16, cycles held before the first auto-repeat (used only with HOLD_REPEAT_EN)
REPEAT_PERIOD, 8, cycles between auto-repeats (used only with HOLD_REPEAT_EN)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-low reset: the block resets on a posedge where reset==0
key_in  input  N  raw asynchronous pin levels
key_level  output  N  debounced pressed state, 1 = pressed regardless of ACTIVE_LOW
key_press  output  N  one-cycle pulse when a channel becomes pressed (plus auto-repeats when enabled)
key_release  output  N  one-cycle pulse when a channel becomes released
any_level  output  1  OR of key_level

Behaviour:
- Reset (reset==0 at a posedge):
  - Every synchronizer flop loads the idle raw level: 1 if ACTIVE_LOW, else 0.
  - Debounce counters clear to 0; stable state clears to 0 (released).
  - key_level, key_press, key_release and any_level all read 0.
  - No pulse appears on the first cycle after reset deasserts.
  - Reset mid-debounce discards the partial count.
- Synchronizer: stage1 <= key_in[i], and stage k <= stage k-1. The normalized sample is s = last stage XOR ACTIVE_LOW.
- Debouncer, per channel (stable register `st`, counter `cnt`, width $clog2(DEBOUNCE_CYCLES+1)):
  - s == st: cnt <= 0.
  - s != st and cnt == DEBOUNCE_CYCLES-1: st <= s, cnt <= 0.
  - s != st otherwise: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count and never reaches st.
- Edge pulses are registered and coincide with the change of key_level:
  - key_press[i] = 1 for exactly the cycle after st goes 0->1.
  - key_release[i] = 1 for exactly the cycle after st goes 1->0.
  - key_press and key_release are never both high on the same channel.
- Latency: let t0 be the posedge at which stage1 first captures a new raw value that is then held. key_level (and its pulse) changes at posedge t0+SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults this is t0+5.
- key_level is the registered st. any_level is combinational OR of key_level, so it has no extra latency.
- Simultaneous events on different channels are handled independently in the same cycle. Multiple pulses in one cycle are allowed.
- No wrap-around: cnt saturates by construction at DEBOUNCE_CYCLES-1.

Optional Feature:
Macro: KEY_CONDITIONER_HOLD_REPEAT_EN
- Defined:
  - Each channel has a hold counter (width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)). It clears on reset, when key_level==0, and on the press edge.
  - While key_level==1, the counter increments each cycle. When the count reaches REPEAT_DELAY, key_press pulses for one cycle.
  - After the first repeat, key_press pulses every REPEAT_PERIOD cycles for as long as the key is held.
  - Release stops repeats immediately; no repeat pulse is issued on or after the release edge.
- Undefined: hold counters are not instantiated. key_press fires only on the debounced 0->1 edge. REPEAT_* parameters are ignored.

Test Plan:
- Reset hold-off: defaults (ACTIVE_LOW=1), key_in=4'hF, drive reset=0 for 3 cycles then 1 for 10 cycles -> all outputs 0 throughout, with no spurious press.
- Clean press and release on channel 0: key_in[0] 1->0 captured at t0 -> key_level[0] and key_press[0] rise at t0+5, key_press[0] high for exactly 1 cycle. Return key_in[0] to 1 at t1 -> key_release[0] pulses at t1+5; key_level[0]=0 from then on.
- Glitch rejection: key_in[1] low for 3 cycles, then high -> key_level[1] stays 0 and no pulses. Holding it low for 4 cycles produces exactly one press.
- Simultaneous channels and mid-operation reset: key_in[2] and key_in[3] both fall at the same t0 -> both press pulses at t0+5 and any_level=1. Assert reset=0 at t0+7 -> all outputs 0 at the next cycle; after reset deasserts with keys still held, presses re-qualify after 5 cycles.
- ACTIVE_LOW=0 build: key_in[0] 0->1 -> key_press[0] pulses after 5 cycles and key_level[0]=1.
- With KEY_CONDITIONER_HOLD_REPEAT_EN defined (REPEAT_DELAY=16, REPEAT_PERIOD=8): hold key 40 cycles after the press edge at cycle P -> key_press pulses at P, P+16, P+24, P+32, P+40. Release -> no further press pulses, one release pulse.

Source files
------------

// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - pin-side and game-side signal bundle for key_conditioner
//
// Purpose: groups the raw key inputs and the conditioned outputs of key_conditioner.
// Signals:
//   key_in      [N] raw asynchronous pin levels
//   key_level   [N] debounced pressed state, 1 = pressed
//   key_press   [N] one-cycle press pulse (plus auto-repeats when enabled)
//   key_release [N] one-cycle release pulse
//   any_level       OR of key_level
// Modports:
//   master - pin/consumer side: drives key_in, observes the outputs
//   slave  - the conditioner itself
interface key_conditioner_if #(
    parameter int N = 4
);
    logic [N-1:0] key_in;
    logic [N-1:0] key_level;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;
    logic         any_level;

    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  any_level
    );

    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output any_level
    );
endinterface

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - multi-channel key synchronizer, debouncer and edge-pulse generator
//
// Purpose: per channel, a SYNC_STAGES-deep synchronizer, a counter debouncer that accepts a
// new level after DEBOUNCE_CYCLES consecutive differing samples, and registered one-cycle
// press/release pulses aligned with the change of key_level.
// Ports:
//   clk    system clock, all logic on posedge
//   reset  synchronous active-low reset
//   bus    key_conditioner_if.slave (key_in in; key_level/key_press/key_release/any_level out)
// Optional feature: define KEY_CONDITIONER_HOLD_REPEAT_EN to add hold auto-repeat on key_press
// (first repeat REPEAT_DELAY cycles after the press edge, then every REPEAT_PERIOD cycles).
module key_conditioner #(
    parameter int N               = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    key_conditioner_if.slave      bus
);
    localparam int   CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic AL = (ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] sync_q [N];
    logic [CW-1:0]          cnt_q  [N];
    logic [CW-1:0]          cnt_d  [N];
    logic [N-1:0]           samp;
    logic [N-1:0]           st_q, st_d;
    logic [N-1:0]           press_q, press_d;
    logic [N-1:0]           rel_q, rel_d;
    logic [N-1:0]           rep_fire;

`ifdef KEY_CONDITIONER_HOLD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(RMAX + 1);

    logic [HW-1:0] hold_q [N];
    logic [HW-1:0] hold_d [N];
    logic [N-1:0]  rep_q, rep_d;

    // rep_q selects the interval: REPEAT_DELAY before the first repeat, REPEAT_PERIOD after.
    // The counter restarts from 0 on every repeat. Holding is only counted while the key was
    // pressed last cycle and stays pressed this cycle, so the press edge and the release edge
    // both clear it and a release can never coincide with a repeat.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            hold_d[i]   = hold_q[i];
            rep_d[i]    = rep_q[i];
            rep_fire[i] = 1'b0;
            if (!st_q[i] || !st_d[i]) begin
                hold_d[i] = '0;
                rep_d[i]  = 1'b0;
            end else if ((hold_q[i] + 1'b1) ==
                         (rep_q[i] ? HW'(REPEAT_PERIOD) : HW'(REPEAT_DELAY))) begin
                hold_d[i]   = '0;
                rep_d[i]    = 1'b1;
                rep_fire[i] = 1'b1;
            end else begin
                hold_d[i] = hold_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                hold_q[i] <= '0;
            end
            rep_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                hold_q[i] <= hold_d[i];
            end
            rep_q <= rep_d;
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
    assign rep_fire          = '0;
`endif

    // Debouncer: cnt counts consecutive samples that disagree with st; the DEBOUNCE_CYCLES-th
    // such sample is accepted, so cnt never goes past DEBOUNCE_CYCLES-1.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            samp[i]  = sync_q[i][SYNC_STAGES-1] ^ AL;
            st_d[i]  = st_q[i];
            cnt_d[i] = '0;
            if (samp[i] != st_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    st_d[i] = samp[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        press_d = (st_d & ~st_q) | rep_fire;
        rel_d   = ~st_d & st_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                sync_q[i] <= {SYNC_STAGES{AL}};
                cnt_q[i]  <= '0;
            end
            st_q    <= '0;
            press_q <= '0;
            rel_q   <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.key_in[i]};
                cnt_q[i]  <= cnt_d[i];
            end
            st_q    <= st_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign bus.key_level   = st_q;
    assign bus.key_press   = press_q;
    assign bus.key_release = rel_q;
    assign bus.any_level   = |st_q;
endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - self-checking bench for key_conditioner (active-low and active-high builds)
module tb_key_conditioner;
    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int RD   = 16;
    localparam int RP   = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] ka, kb;
    bit           mirror;
    int           checks, passed;

    key_conditioner_if #(.N(N)) if_a ();
    key_conditioner_if #(.N(N)) if_b ();

    assign if_a.key_in = ka;
    assign if_b.key_in = kb;

    key_conditioner #(.N(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1),
                      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
        dut_a (.clk(clk), .reset(rst_n), .bus(if_a));

    key_conditioner #(.N(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(0),
                      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
        dut_b (.clk(clk), .reset(rst_n), .bus(if_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a pressed sample reaches the debouncer SYNC edges after capture, and a
    // channel flips its level once the last DB samples all disagree with the current level.
    bit           pipe [2][N][SYNC];
    bit           win  [2][N][DB];
    bit           lvl  [2][N];
    int           held [2][N];
    logic [N-1:0] xl [2], xp [2], xr [2];

    task automatic model_edge(input int u, input logic [N-1:0] raw, input logic rn, input bit al);
        bit s, alld;
        for (int c = 0; c < N; c++) begin
            xp[u][c] = 1'b0;
            xr[u][c] = 1'b0;
            if (!rn) begin
                for (int j = 0; j < SYNC; j++) pipe[u][c][j] = 1'b0;
                for (int j = 0; j < DB; j++) win[u][c][j] = 1'b0;
                lvl[u][c]  = 1'b0;
                held[u][c] = 0;
            end else begin
                s = pipe[u][c][SYNC-1];
                for (int j = SYNC - 1; j > 0; j--) pipe[u][c][j] = pipe[u][c][j-1];
                pipe[u][c][0] = raw[c] ^ al;
                for (int j = DB - 1; j > 0; j--) win[u][c][j] = win[u][c][j-1];
                win[u][c][0] = s;
                alld = 1'b1;
                for (int j = 0; j < DB; j++) if (win[u][c][j] == lvl[u][c]) alld = 1'b0;
                if (alld) begin
                    lvl[u][c]  = ~lvl[u][c];
                    held[u][c] = 0;
                    if (lvl[u][c]) xp[u][c] = 1'b1;
                    else           xr[u][c] = 1'b1;
                end else if (lvl[u][c]) begin
                    held[u][c]++;
`ifdef KEY_CONDITIONER_HOLD_REPEAT_EN
                    if (held[u][c] >= RD && ((held[u][c] - RD) % RP) == 0) xp[u][c] = 1'b1;
`endif
                end
            end
            xl[u][c] = lvl[u][c];
        end
    endtask

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            if (mirror) kb = ~ka;
            @(posedge clk);
            model_edge(0, ka, rst_n, 1'b1);
            model_edge(1, kb, rst_n, 1'b0);
            #1;
            check("a.level",   if_a.key_level,          xl[0]);
            check("a.press",   if_a.key_press,          xp[0]);
            check("a.release", if_a.key_release,        xr[0]);
            check("a.any",     {3'b0, if_a.any_level},  {3'b0, |xl[0]});
            check("b.level",   if_b.key_level,          xl[1]);
            check("b.press",   if_b.key_press,          xp[1]);
            check("b.release", if_b.key_release,        xr[1]);
            check("b.any",     {3'b0, if_b.any_level},  {3'b0, |xl[1]});
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        mirror = 1'b1;
        ka     = 4'hF;
        kb     = 4'h0;
        rst_n  = 1'b0;

        // Reset hold-off with idle inputs
        step(3);
        check("rst.level", if_a.key_level, 4'h0);
        rst_n = 1'b1;
        step(10);
        check("idle.press", if_a.key_press, 4'h0);

        // Clean press / release on channel 0: level and pulse at t0+5
        ka[0] = 1'b0;
        step(5);
        check("ch0.level_t0+4", if_a.key_level, 4'h0);
        step(1);
        check("ch0.level_t0+5", if_a.key_level, 4'b0001);
        check("ch0.press_t0+5", if_a.key_press, 4'b0001);
        check("ch0b.press_t0+5", if_b.key_press, 4'b0001);
        step(1);
        check("ch0.press_t0+6", if_a.key_press, 4'h0);
        step(8);
        ka[0] = 1'b1;
        step(5);
        check("ch0.release_t1+4", if_a.key_release, 4'h0);
        step(1);
        check("ch0.release_t1+5", if_a.key_release, 4'b0001);
        step(6);

        // Glitch of DB-1 samples is rejected; DB samples qualify
        ka[1] = 1'b0;
        step(3);
        ka[1] = 1'b1;
        step(10);
        check("glitch.level", if_a.key_level, 4'h0);
        ka[1] = 1'b0;
        step(4);
        ka[1] = 1'b1;
        step(2);
        check("glitch4.press", if_a.key_press, 4'b0010);
        step(12);

        // Simultaneous channels, then reset mid-hold
        ka[3:2] = 2'b00;
        step(6);
        check("sim.press", if_a.key_press, 4'b1100);
        check("sim.any", {3'b0, if_a.any_level}, 4'b0001);
        step(1);
        rst_n = 1'b0;
        step(1);
        check("midrst.level", if_a.key_level, 4'h0);
        rst_n = 1'b1;
        step(5);
        check("requal.level_early", if_a.key_level, 4'h0);
        step(1);
        check("requal.press", if_a.key_press, 4'b1100);
        ka = 4'hF;
        step(10);

        // Long hold on channel 0 (exercises auto-repeat when enabled), then release
        ka[0] = 1'b0;
        step(56);
        ka[0] = 1'b1;
        step(12);

        // Randomized toggling on both builds, with occasional resets
        mirror = 1'b0;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(3) == 0) ka[c] = ~ka[c];
                if ($urandom_range(3) == 0) kb[c] = ~kb[c];
            end
            rst_n = ($urandom_range(149) != 0);
            step(1);
        end
        rst_n = 1'b1;
        step(5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
